blvds_frame_gen: RTL and testbench

Test-pattern BLVDS frame generator that sits directly upstream of the BLVDS frame receiver and drives its 18-bit input bus. It emits complete frames: header word, incrementing payload, epilog word, then an inter-frame gap. It is used on the bench and in loopback builds to exercise the receiver, FIFO switch and error counters without external hardware.

---
 rtl/blvds_frame_gen_if.sv | 40 ++++
 rtl/blvds_frame_gen.sv | 146 ++++++++++++++
 tb/tb_blvds_frame_gen.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/blvds_frame_gen_if.sv
// Bus between the BLVDS test-pattern generator and its controller/consumer.
// With BLVDS_FRAME_GEN_ERR_INJECT_EN defined, two corruption request lines are added.
interface blvds_frame_gen_if;
  logic        iENABLE;
  logic        iSINGLE;
`ifdef BLVDS_FRAME_GEN_ERR_INJECT_EN
  logic        iERR_HEAD;
  logic        iERR_EPILOG;
`endif
  logic [17:0] oDATA_BLVDS;
  logic        oBUSY;
  logic        oFRAME_DONE;
  logic [15:0] oFRAME_CNT;

  modport master (
    input  iENABLE,
    input  iSINGLE,
`ifdef BLVDS_FRAME_GEN_ERR_INJECT_EN
    input  iERR_HEAD,
    input  iERR_EPILOG,
`endif
    output oDATA_BLVDS,
    output oBUSY,
    output oFRAME_DONE,
    output oFRAME_CNT
  );

  modport slave (
    output iENABLE,
    output iSINGLE,
`ifdef BLVDS_FRAME_GEN_ERR_INJECT_EN
    output iERR_HEAD,
    output iERR_EPILOG,
`endif
    input  oDATA_BLVDS,
    input  oBUSY,
    input  oFRAME_DONE,
    input  oFRAME_CNT
  );
endinterface

// File: rtl/blvds_frame_gen.sv
// Test-pattern BLVDS frame generator: header, incrementing payload, epilog, gap.
// Optional header/epilog corruption is built when BLVDS_FRAME_GEN_ERR_INJECT_EN is defined.
module blvds_frame_gen #(
  parameter logic [15:0] HEADER      = 16'hA5A5,
  parameter logic [15:0] EPILOG      = 16'h5A5A,
  parameter logic [9:0]  PAYLOAD_LEN = 10'd256,
  parameter logic [7:0]  FRAME_GAP   = 8'd100
) (
  input logic               iCLK,
  input logic               iRST_N,
  blvds_frame_gen_if.master fg
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_PAYLOAD,
    ST_EPILOG,
    ST_GAP
  } state_t;

  state_t      state_q, state_nxt;
  logic [9:0]  cnt_q, cnt_nxt;
  logic [17:0] bus_q, bus_nxt;
  logic        busy_q, busy_nxt;
  logic        done_q, done_nxt;
  logic [15:0] frame_cnt_q, frame_cnt_nxt;
  logic [15:0] head_word, epi_word;
  logic        start;
  state_t      gap_exit;

  assign start    = fg.iENABLE | fg.iSINGLE;
  assign gap_exit = fg.iENABLE ? ST_HEAD : ST_IDLE;

`ifdef BLVDS_FRAME_GEN_ERR_INJECT_EN
  logic err_head_q, err_head_nxt;
  logic err_epi_q, err_epi_nxt;

  function automatic logic [15:0] marker(input logic [15:0] nominal, input logic corrupt);
    return corrupt ? ~nominal : nominal;
  endfunction

  assign head_word = marker(HEADER, err_head_q);
  assign epi_word  = marker(EPILOG, err_epi_q);

  // A flag is consumed on entry to its marker word; a pulse in that same cycle re-arms it.
  always_comb begin
    err_head_nxt = err_head_q | fg.iERR_HEAD;
    err_epi_nxt  = err_epi_q | fg.iERR_EPILOG;
    if (state_nxt == ST_HEAD) err_head_nxt = fg.iERR_HEAD;
    if (state_nxt == ST_EPILOG) err_epi_nxt = fg.iERR_EPILOG;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      err_head_q <= 1'b0;
      err_epi_q  <= 1'b0;
    end else begin
      err_head_q <= err_head_nxt;
      err_epi_q  <= err_epi_nxt;
    end
  end
`else
  assign head_word = HEADER;
  assign epi_word  = EPILOG;
`endif

  always_comb begin
    state_nxt     = state_q;
    cnt_nxt       = cnt_q;
    frame_cnt_nxt = frame_cnt_q;
    bus_nxt       = 18'h0;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_nxt = ST_HEAD;
      end
      ST_HEAD: begin
        state_nxt = ST_PAYLOAD;
        cnt_nxt   = 10'd0;
      end
      ST_PAYLOAD: begin
        if (cnt_q == PAYLOAD_LEN - 10'd1) state_nxt = ST_EPILOG;
        else                               cnt_nxt   = cnt_q + 10'd1;
      end
      ST_EPILOG: begin
        frame_cnt_nxt = frame_cnt_q + 16'd1;
        cnt_nxt       = 10'd0;
        if (FRAME_GAP == 8'd0) state_nxt = gap_exit;
        else                   state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == {2'b00, FRAME_GAP} - 10'd1) state_nxt = gap_exit;
        else                                      cnt_nxt   = cnt_q + 10'd1;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so the bus word is registered with it.
    case (state_nxt)
      ST_HEAD: begin
        bus_nxt  = {2'b11, head_word};
        busy_nxt = 1'b1;
      end
      ST_PAYLOAD: begin
        bus_nxt  = {2'b11, (state_q == ST_HEAD) ? frame_cnt_q : bus_q[15:0] + 16'd1};
        busy_nxt = 1'b1;
      end
      ST_EPILOG: begin
        bus_nxt  = {2'b11, epi_word};
        busy_nxt = 1'b1;
        done_nxt = 1'b1;
      end
      ST_GAP: begin
        busy_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 10'd0;
      bus_q       <= 18'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      bus_q       <= bus_nxt;
      busy_q      <= busy_nxt;
      done_q      <= done_nxt;
      frame_cnt_q <= frame_cnt_nxt;
    end
  end

  assign fg.oDATA_BLVDS = bus_q;
  assign fg.oBUSY       = busy_q;
  assign fg.oFRAME_DONE = done_q;
  assign fg.oFRAME_CNT  = frame_cnt_q;

endmodule

// File: tb/tb_blvds_frame_gen.sv
// Directed/randomized bench for blvds_frame_gen against a frame-level word model.
// Default-parameter instance plus a PAYLOAD_LEN=1, FRAME_GAP=0 instance for back-to-back frames.
module tb_blvds_frame_gen;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  blvds_frame_gen_if bus_a ();
  blvds_frame_gen_if bus_b ();

  blvds_frame_gen dut_a (.iCLK(clk), .iRST_N(rst_n), .fg(bus_a));
  blvds_frame_gen #(.PAYLOAD_LEN(10'd1), .FRAME_GAP(8'd0)) dut_b (.iCLK(clk), .iRST_N(rst_n), .fg(bus_b));

  localparam int          LA  = 256;
  localparam int          GA  = 100;
  localparam logic [15:0] HDR = 16'hA5A5;
  localparam logic [15:0] EPI = 16'h5A5A;

  int errors = 0;
  int checks = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Word at offset t from the header of a frame with the given seed.
  function automatic logic [17:0] model_word(input int t, input int plen, input logic [15:0] seed,
                                             input logic [15:0] hdr, input logic [15:0] epi);
    if (t == 0) return {2'b11, hdr};
    if (t <= plen) return {2'b11, seed + 16'(t - 1)};
    if (t == plen + 1) return {2'b11, epi};
    return 18'h0;
  endfunction

  task automatic sample(input bit b, output logic [17:0] ob, output logic obusy,
                        output logic odone, output logic [15:0] ocnt);
    ob    = b ? bus_b.oDATA_BLVDS : bus_a.oDATA_BLVDS;
    obusy = b ? bus_b.oBUSY : bus_a.oBUSY;
    odone = b ? bus_b.oFRAME_DONE : bus_a.oFRAME_DONE;
    ocnt  = b ? bus_b.oFRAME_CNT : bus_a.oFRAME_CNT;
  endtask

  // Checks n cycles of a frame starting at its header cycle; optionally drops iENABLE,
  // pulses iSINGLE (must be ignored) and arms corruption flags at given offsets.
  task automatic run_frame(input bit b, input int plen, input int gap, input int n,
                           input logic [15:0] seed, input logic [15:0] cnt0,
                           input logic [15:0] hdr, input logic [15:0] epi,
                           input int drop_at, input int noise_at, input int eh_at, input int ee_at);
    logic [17:0] ob;
    logic        obusy, odone;
    logic [15:0] ocnt, cnt1;
    cnt1 = cnt0 + 16'd1;
    for (int t = 0; t < n; t++) begin
      sample(b, ob, obusy, odone, ocnt);
      chk($sformatf("dut%0d bus seed=%0h t=%0d", b, seed, t), 32'(ob),
          32'(model_word(t, plen, seed, hdr, epi)));
      chk($sformatf("dut%0d busy t=%0d", b, t), 32'(obusy), 32'(1));
      chk($sformatf("dut%0d done t=%0d", b, t), 32'(odone), 32'(t == plen + 1));
      chk($sformatf("dut%0d cnt t=%0d", b, t), 32'(ocnt), 32'((t <= plen + 1) ? cnt0 : cnt1));
      if (b) begin
        if (t == drop_at) bus_b.iENABLE = 1'b0;
      end else begin
        if (t == drop_at) bus_a.iENABLE = 1'b0;
        bus_a.iSINGLE = (t == noise_at);
      end
`ifdef BLVDS_FRAME_GEN_ERR_INJECT_EN
      bus_a.iERR_HEAD   = (t == eh_at);
      bus_a.iERR_EPILOG = (t == ee_at);
`endif
      tick;
    end
    bus_a.iSINGLE = 1'b0;
`ifdef BLVDS_FRAME_GEN_ERR_INJECT_EN
    bus_a.iERR_HEAD   = 1'b0;
    bus_a.iERR_EPILOG = 1'b0;
`endif
    if (eh_at < -1 || ee_at < -1) $display("note: unused injection offsets");
  endtask

  task automatic idle_check(input bit b, input int n, input logic [15:0] cnt);
    logic [17:0] ob;
    logic        obusy, odone;
    logic [15:0] ocnt;
    for (int i = 0; i < n; i++) begin
      sample(b, ob, obusy, odone, ocnt);
      chk($sformatf("dut%0d idle bus", b), 32'(ob), 32'(0));
      chk($sformatf("dut%0d idle busy", b), 32'(obusy), 32'(0));
      chk($sformatf("dut%0d idle done", b), 32'(odone), 32'(0));
      chk($sformatf("dut%0d idle cnt", b), 32'(ocnt), 32'(cnt));
      tick;
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  initial begin
    logic [17:0] ob;
    logic        obusy, odone;
    logic [15:0] ocnt;
    int          drop;

    rst_n         = 1'b0;
    bus_a.iENABLE = 1'b0;
    bus_a.iSINGLE = 1'b0;
    bus_b.iENABLE = 1'b0;
    bus_b.iSINGLE = 1'b0;
`ifdef BLVDS_FRAME_GEN_ERR_INJECT_EN
    bus_a.iERR_HEAD   = 1'b0;
    bus_a.iERR_EPILOG = 1'b0;
    bus_b.iERR_HEAD   = 1'b0;
    bus_b.iERR_EPILOG = 1'b0;
`endif
    tick;
    tick;
    idle_check(1'b0, 1, 16'd0);
    idle_check(1'b1, 1, 16'd0);
    rst_n = 1'b1;
    tick;

    // Single frame from a one-cycle iSINGLE pulse, with an ignored iSINGLE mid-frame.
    bus_a.iSINGLE = 1'b1;
    tick;
    bus_a.iSINGLE = 1'b0;
    run_frame(1'b0, LA, GA, LA + 2 + GA, 16'd0, 16'd0, HDR, EPI, -1,
              int'($urandom_range(1, LA + GA)), -1, -1);
    idle_check(1'b0, 3, 16'd1);

    // Continuous generation: three frames, seeds 0,1,2, enable dropped at a random point in the third.
    do_reset();
    idle_check(1'b0, 1, 16'd0);
    bus_a.iENABLE = 1'b1;
    tick;
    run_frame(1'b0, LA, GA, LA + 2 + GA, 16'd0, 16'd0, HDR, EPI, -1, -1, -1, -1);
    run_frame(1'b0, LA, GA, LA + 2 + GA, 16'd1, 16'd1, HDR, EPI, -1, -1, -1, -1);
    drop = int'($urandom_range(0, LA + 1 + GA));
    run_frame(1'b0, LA, GA, LA + 2 + GA, 16'd2, 16'd2, HDR, EPI, drop, -1, -1, -1);
    idle_check(1'b0, 4, 16'd3);

    // Enable dropped at the 10th payload word: frame and gap still complete.
    bus_a.iENABLE = 1'b1;
    tick;
    run_frame(1'b0, LA, GA, LA + 2 + GA, 16'd3, 16'd3, HDR, EPI, 10, -1, -1, -1);
    idle_check(1'b0, int'($urandom_range(2, 6)), 16'd4);

    // Random drop point plus a stray iSINGLE while busy.
    bus_a.iENABLE = 1'b1;
    bus_a.iSINGLE = 1'b1;
    tick;
    bus_a.iSINGLE = 1'b0;
    drop = int'($urandom_range(0, LA + 1 + GA));
    run_frame(1'b0, LA, GA, LA + 2 + GA, 16'd4, 16'd4, HDR, EPI, drop,
              int'($urandom_range(0, LA + 1 + GA)), -1, -1);
    idle_check(1'b0, 2, 16'd5);

    // Reset while payload word 50 is on the bus.
    bus_a.iSINGLE = 1'b1;
    tick;
    bus_a.iSINGLE = 1'b0;
    run_frame(1'b0, LA, GA, 51, 16'd5, 16'd5, HDR, EPI, -1, -1, -1, -1);
    sample(1'b0, ob, obusy, odone, ocnt);
    chk("payload word 50 before reset", 32'(ob), 32'({2'b11, 16'd55}));
    #2;
    rst_n = 1'b0;
    #1;
    sample(1'b0, ob, obusy, odone, ocnt);
    chk("async reset bus", 32'(ob), 32'(0));
    chk("async reset busy", 32'(obusy), 32'(0));
    chk("async reset cnt", 32'(ocnt), 32'(0));
    tick;
    rst_n = 1'b1;
    tick;
    bus_a.iSINGLE = 1'b1;
    tick;
    bus_a.iSINGLE = 1'b0;
    run_frame(1'b0, LA, GA, LA + 2 + GA, 16'd0, 16'd0, HDR, EPI, -1, -1, -1, -1);
    idle_check(1'b0, 2, 16'd1);

    // Back-to-back minimum frames, then the seed wrap from 16'hFFFF.
    idle_check(1'b1, 1, 16'd0);
    bus_b.iENABLE = 1'b1;
    tick;
    for (int f = 0; f < 3; f++)
      run_frame(1'b1, 1, 0, 3, 16'(f), 16'(f), HDR, EPI, (f == 2) ? 0 : -1, -1, -1, -1);
    idle_check(1'b1, 2, 16'd3);
    force dut_b.frame_cnt_q = 16'hFFFF;
    tick;
    release dut_b.frame_cnt_q;
    idle_check(1'b1, 1, 16'hFFFF);
    bus_b.iENABLE = 1'b1;
    tick;
    run_frame(1'b1, 1, 0, 3, 16'hFFFF, 16'hFFFF, HDR, EPI, -1, -1, -1, -1);
    run_frame(1'b1, 1, 0, 3, 16'h0000, 16'h0000, HDR, EPI, 0, -1, -1, -1);
    idle_check(1'b1, 2, 16'd1);

`ifdef BLVDS_FRAME_GEN_ERR_INJECT_EN
    // Corruption one-shots: header of frame 2 and epilog of frame 2 inverted, frame 3 nominal.
    bus_a.iENABLE = 1'b1;
    tick;
    run_frame(1'b0, LA, GA, LA + 2 + GA, 16'd1, 16'd1, HDR, EPI, -1, -1, 5, -1);
    run_frame(1'b0, LA, GA, LA + 2 + GA, 16'd2, 16'd2, ~HDR, ~EPI, -1, -1, -1, 5);
    run_frame(1'b0, LA, GA, LA + 2 + GA, 16'd3, 16'd3, HDR, EPI, 0, -1, -1, -1);
    idle_check(1'b0, 2, 16'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
